// File: rtl/letter_sequencer.sv
// Message buffer plus playback FSM that steps stored letter codes out to a
// 16-segment decoder, holding each for a dwell time followed by a blank gap.
module letter_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter int unsigned LOOP         = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [5:0]               wr_data,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  output logic [5:0]               letter,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned GAP_LOAD_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_LOAD_INT);

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [5:0]      letter_q, letter_d;
  logic            done_q, done_d;
  logic            wr_err_q, wr_err_d;
  logic            mem_we;
  logic [5:0]      mem_q [DEPTH];

  logic            valid_code;
  logic            last_letter;
  logic [AW-1:0]   idx_inc;

  assign valid_code  = (wr_data != 6'd0) && (wr_data <= 6'd52);
  assign idx_inc     = idx_q + 1'b1;
  assign last_letter = ((CW'(idx_q) + 1'b1) == count_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    timer_d  = timer_q;
    letter_d = letter_q;
    done_d   = 1'b0;
    wr_err_d = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        letter_d = 6'd0;
        if (clear) begin
          count_d = '0;
        end else if (wr_en) begin
          if (valid_code && (count_q < CW'(DEPTH))) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            wr_err_d = 1'b1;
          end
        end
        // A simultaneous clear empties the buffer, so start must not launch with it.
        if (start && !stop && !clear && (count_q != '0)) begin
          state_d  = StShow;
          idx_d    = '0;
          timer_d  = DWELL_LOAD;
          letter_d = mem_q[0];
        end
      end

      StShow, StGap: begin
        if (wr_en) begin
          wr_err_d = 1'b1;
        end
        if (stop) begin
          state_d  = StIdle;
          letter_d = 6'd0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if ((state_q == StShow) && (GAP_CYCLES != 0)) begin
          state_d  = StGap;
          timer_d  = GAP_LOAD;
          letter_d = 6'd0;
        end else if (!last_letter) begin
          state_d  = StShow;
          idx_d    = idx_inc;
          timer_d  = DWELL_LOAD;
          letter_d = mem_q[idx_inc];
        end else if (LOOP != 0) begin
          state_d  = StShow;
          idx_d    = '0;
          timer_d  = DWELL_LOAD;
          letter_d = mem_q[0];
        end else begin
          state_d  = StIdle;
          letter_d = 6'd0;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d  = StIdle;
        letter_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      letter_q <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      letter_q <= letter_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Buffer RAM is not reset; entries at or above count are never read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q[AW-1:0]] <= wr_data;
    end
  end

  assign letter = letter_q;
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign wr_err = wr_err_q;
  assign count  = count_q;

endmodule

// File: tb/tb_letter_sequencer.sv
// Self-checking bench: a single-pass and a looping instance share stimulus and are
// compared every cycle against a playback-position model of the message.
module tb_letter_sequencer;

  localparam int DEP = 4;
  localparam int DW  = 3;
  localparam int GP  = 1;
  localparam int P   = DW + GP;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_data = 6'd0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;

  logic [5:0] letter0, letter1;
  logic       busy0, busy1, done0, done1, err0, err1;
  logic [2:0] count0, count1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per instance, buffer contents plus a playback cycle index k.
  logic [5:0] m_buf [2][DEP];
  int         m_cnt [2];
  int         m_k   [2];
  bit         m_play[2];
  bit         e_done[2];
  bit         e_err [2];

  letter_sequencer #(.DEPTH(DEP), .DWELL_CYCLES(DW), .GAP_CYCLES(GP), .LOOP(0)) dut_once (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .start(start), .stop(stop), .letter(letter0), .busy(busy0), .done(done0),
    .wr_err(err0), .count(count0)
  );

  letter_sequencer #(.DEPTH(DEP), .DWELL_CYCLES(DW), .GAP_CYCLES(GP), .LOOP(1)) dut_loop (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .start(start), .stop(stop), .letter(letter1), .busy(busy1), .done(done1),
    .wr_err(err1), .count(count1)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input int i, input bit lp);
    int sz;
    sz = m_cnt[i];
    e_done[i] = 1'b0;
    e_err[i]  = 1'b0;
    if (rst) begin
      m_cnt[i]  = 0;
      m_play[i] = 1'b0;
      m_k[i]    = 0;
    end else if (m_play[i]) begin
      if (wr_en) e_err[i] = 1'b1;
      if (stop) begin
        m_play[i] = 1'b0;
      end else begin
        m_k[i]++;
        if (m_k[i] == m_cnt[i] * P) begin
          m_k[i] = 0;
          if (!lp) begin
            m_play[i] = 1'b0;
            e_done[i] = 1'b1;
          end
        end
      end
    end else begin
      if (clear) begin
        m_cnt[i] = 0;
      end else if (wr_en) begin
        if (wr_data >= 6'd1 && wr_data <= 6'd52 && sz < DEP) begin
          m_buf[i][sz] = wr_data;
          m_cnt[i]     = sz + 1;
        end else begin
          e_err[i] = 1'b1;
        end
      end
      if (start && !stop && !clear && sz > 0) begin
        m_play[i] = 1'b1;
        m_k[i]    = 0;
      end
    end
  endtask

  function automatic logic [11:0] exp_vec(input int i);
    logic [5:0] l;
    l = 6'd0;
    if (m_play[i] && (m_k[i] % P) < DW) l = m_buf[i][m_k[i] / P];
    return {l, m_play[i], e_done[i], e_err[i], 3'(m_cnt[i])};
  endfunction

  function automatic logic [11:0] obs_vec(input int i);
    if (i == 0) return {letter0, busy0, done0, err0, count0};
    return {letter1, busy1, done1, err1, count1};
  endfunction

  task automatic cyc(input bit w, input logic [5:0] d, input bit c, input bit s, input bit p);
    wr_en = w; wr_data = d; clear = c; start = s; stop = p;
    @(posedge clk);
    model_edge(0, 1'b0);
    model_edge(1, 1'b1);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_vec(d) !== 12'h000) begin
        n_bad++;
        $display("FAIL reset dut%0d: got %h want 000 (letter,busy,done,err,count)", d, obs_vec(d));
      end
    end
  endtask

  task automatic test_single_pass;
    logic [5:0] seq [12];
    bit saw_done1;
    seq = '{8, 8, 8, 0, 9, 9, 9, 0, 1, 1, 1, 0};
    saw_done1 = 1'b0;
    cyc(1, 8, 0, 0, 0);
    cyc(1, 9, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int j = 0; j < 12; j++) begin
      n_cmp++;
      if (letter0 !== seq[j]) begin
        n_bad++;
        $display("FAIL single_pass seq[%0d]: got %0d want %0d", j, letter0, seq[j]);
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_bad++;
          $display("FAIL single_pass dut%0d j=%0d: got %h want %h", d, j, obs_vec(d), exp_vec(d));
        end
      end
      if (done1) saw_done1 = 1'b1;
      cyc(0, 0, 0, 0, 0);
    end
    n_cmp++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || letter0 !== 6'd0) begin
      n_bad++;
      $display("FAIL single_pass_done: got done=%b busy=%b letter=%0d want 1 0 0",
               done0, busy0, letter0);
    end
    n_cmp++;
    if (letter1 !== 6'd8 || busy1 !== 1'b1 || saw_done1 || done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL loop_wrap: got letter=%0d busy=%b done_seen=%b want 8 1 0",
               letter1, busy1, saw_done1 | done1);
    end
    cyc(0, 0, 0, 0, 0);
    n_cmp++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pass_after: got done=%b busy=%b want 0 0", done0, busy0);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_write_errors;
    logic [5:0] codes [7];
    int errs;
    codes = '{0, 53, 1, 26, 27, 52, 5};
    errs = 0;
    cyc(0, 0, 1, 0, 0);
    for (int j = 0; j < 7; j++) begin
      cyc(1, codes[j], 0, 0, 0);
      if (err0) errs++;
      n_cmp++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL write_err j=%0d: got %h want %h", j, obs_vec(0), exp_vec(0));
      end
      if (j == 2) begin
        n_cmp++;
        if (errs != 2 || count0 !== 3'd1) begin
          n_bad++;
          $display("FAIL write_err_bad_codes: got errs=%0d count=%0d want 2 1", errs, count0);
        end
      end
    end
    n_cmp++;
    if (err0 !== 1'b1 || count0 !== 3'd4) begin
      n_bad++;
      $display("FAIL write_err_full: got err=%b count=%0d want 1 4", err0, count0);
    end
  endtask

  task automatic test_stop_restart;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 8, 0, 0, 0);
    cyc(1, 9, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int j = 0; j < 5; j++) cyc(0, 0, 0, 0, 0);
    n_cmp++;
    if (letter0 !== 6'd9) begin
      n_bad++;
      $display("FAIL stop_position: got letter=%0d want 9", letter0);
    end
    cyc(0, 0, 0, 0, 1);
    n_cmp++;
    if (letter0 !== 6'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || count0 !== 3'd3) begin
      n_bad++;
      $display("FAIL stop: got letter=%0d busy=%b done=%b count=%0d want 0 0 0 3",
               letter0, busy0, done0, count0);
    end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (letter0 !== 6'd8 || busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL restart: got letter=%0d busy=%b want 8 1", letter0, busy0);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_clear_priority;
    cyc(1, 6'd5, 1, 0, 0);
    n_cmp++;
    if (count0 !== 3'd0 || err0 !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_wins: got count=%0d err=%b want 0 0", count0, err0);
    end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL start_empty: got busy=%b%b want 00", busy0, busy1);
    end
  endtask

  task automatic test_reset_mid_gap;
    cyc(1, 7, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, 0);
    n_cmp++;
    if (letter0 !== 6'd0 || busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_reached: got letter=%0d busy=%b want 0 1", letter0, busy0);
    end
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_vec(d) !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_mid_gap dut%0d: got %h want 000", d, obs_vec(d));
      end
    end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL start_after_reset: got busy=%b%b want 00", busy0, busy1);
    end
  endtask

  task automatic test_random;
    bit w, c, s, p;
    logic [5:0] d;
    for (int j = 0; j < 600; j++) begin
      w = ($urandom_range(99) < 35);
      d = 6'($urandom_range(63));
      c = ($urandom_range(99) < 3);
      s = ($urandom_range(99) < 12);
      p = ($urandom_range(99) < 3);
      rst = ($urandom_range(199) == 0);
      cyc(w, d, c, s, p);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL random dut%0d j=%0d: got %h want %h (letter,busy,done,err,count)",
                   k, j, obs_vec(k), exp_vec(k));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_k[i] = 0; m_play[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
    end
    test_reset();
    test_single_pass();
    test_write_errors();
    test_stop_restart();
    test_clear_priority();
    test_reset_mid_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/letter_sequencer.md
LETTER_SEQUENCER -- requirements
Module: letter_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning message buffer entries, power of two, 2 to 64.
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 25_000_000, meaning clk cycles each letter is shown, at least 1.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2_500_000, meaning clk cycles of blank (code 0) after each letter; 0 means no gap.
REQ-004 The block SHALL have parameter LOOP, default 1, meaning 1 = repeat the message forever and 0 = play it once.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port wr_en, input, 1 bit: append wr_data to the buffer.
REQ-008 The block SHALL have port wr_data, input, 6 bits: letter code, 1-26 = A-Z and 27-52 = a-z.
REQ-009 The block SHALL have port clear, input, 1 bit: empty the buffer.
REQ-010 The block SHALL have port start, input, 1 bit: begin playback.
REQ-011 The block SHALL have port stop, input, 1 bit: abort playback.
REQ-012 The block SHALL have port letter, output, 6 bits, registered: code driven to the downstream 16-segment decoder.
REQ-013 The block SHALL have port busy, output, 1 bit: high in SHOW or GAP.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a single-pass playback completes.
REQ-015 The block SHALL have port wr_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored letters.

Function
REQ-017 The FSM SHALL have three states: IDLE (letter=0), SHOW (letter=buf[idx]) and GAP (letter=0).
REQ-018 In IDLE, a write with wr_en=1, code 1-52 and count<DEPTH SHALL store the code at buf[count] and increment count the next cycle.
REQ-019 A write with code 0 or code 53-63, a write with count==DEPTH, or a write while busy=1 SHALL be dropped, with wr_err=1 the next cycle.
REQ-020 clear in IDLE SHALL set count=0 the next cycle; if clear and wr_en are both high, clear SHALL win, no write SHALL occur and wr_err SHALL stay 0.
REQ-021 clear while busy SHALL be ignored.
REQ-022 start in IDLE with count>0 SHALL move the FSM to SHOW with idx=0, so letter=buf[0] and busy=1 in the cycle after start.
REQ-023 start in IDLE with count==0 SHALL be ignored.
REQ-024 start while busy SHALL be ignored.
REQ-025 SHOW SHALL last exactly DWELL_CYCLES cycles, then go to GAP, or to the next step (REQ-027) if GAP_CYCLES=0.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles.
REQ-027 At the end of a letter, if idx<count-1 the block SHALL increment idx and enter SHOW.
REQ-028 At the end of the last letter (idx==count-1), if LOOP=1 the block SHALL set idx=0 and enter SHOW with no extra cycle.
REQ-029 At the end of the last letter, if LOOP=0 the block SHALL enter IDLE with letter=0, busy=0 and done=1 for one cycle.
REQ-030 stop in SHOW or GAP SHALL force IDLE, letter=0 and busy=0 the next cycle, with no done pulse and the buffer contents and count kept.
REQ-031 If start and stop are both high in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-032 The dwell/gap counter SHALL be wide enough for max(DWELL_CYCLES,GAP_CYCLES) and SHALL reload at every state entry.
REQ-033 letter SHALL never carry a code above 52.

Reset
REQ-034 While rst is high at a clock edge, next state SHALL be IDLE with letter=0, busy=0, done=0, wr_err=0, count=0, idx=0 and the dwell counter 0.
REQ-035 rst asserted mid-playback SHALL abort it with no done pulse.
REQ-036 Buffer RAM contents need not be cleared by reset but SHALL be unreachable because count=0.

Verification (DEPTH=4, DWELL_CYCLES=3, GAP_CYCLES=1)
REQ-037 Scenario 1, LOOP=0: write 8, 9, 1 then pulse start -> letter shows 8,8,8,0,9,9,9,0,1,1,1,0, then done=1 in the IDLE cycle, then busy=0.
REQ-038 Scenario 2, LOOP=1, same buffer: after the third letter's gap, letter=8 on the next cycle and done never asserts.
REQ-039 Scenario 3: write codes 0, 53 and 1 -> wr_err pulses twice and count=1; write 4 more codes -> the fifth write gives wr_err=1 and count=4.
REQ-040 Scenario 4: pulse stop on the second SHOW cycle of letter 9 -> letter=0 and busy=0 the next cycle, done=0, count unchanged; then pulse start -> playback restarts at buf[0].
REQ-041 Scenario 5: assert clear and wr_en together -> count=0 and wr_err=0; pulse start with count=0 -> busy stays 0.
REQ-042 Scenario 6: assert rst mid-GAP -> all outputs 0 next cycle; pulse start before any new write -> no playback.
